// File: rtl/monitor_trace_buffer_pkg.sv
// Shared definitions for the monitor trace buffer.
//   - Default geometry (depth, data width, timestamp width).
//   - Width of the saturating drop counter.
//   - trace_rec_t: field layout of one trace record at the default widths.
//     The RTL packs records flat, as {ts, aktv, out_0, out_1}, in this same
//     order, so that non-default widths work too.
//   - sat_inc: saturating increment for the drop counter.
package monitor_trace_buffer_pkg;

    localparam int DEF_DEPTH  = 8;
    localparam int DEF_DATA_W = 64;
    localparam int DEF_TS_W   = 32;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [DEF_TS_W-1:0]          ts;
        logic [1:0]                   aktv;   // {output_1_aktv, output_0_aktv}
        logic signed [DEF_DATA_W-1:0] out_0;
        logic signed [DEF_DATA_W-1:0] out_1;
    } trace_rec_t;

    // Sticks at all ones instead of wrapping back to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] v);
        return (&v) ? v : v + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/monitor_trace_buffer_fifo.sv
// trace_fifo: synchronous FIFO of DEPTH flat records, each W bits wide.
//   clk, rst     : clock; asynchronous active-high reset that empties the FIFO
//                  and zeroes the storage.
//   push_i       : write push_data_i. The write is ignored when the FIFO is
//                  full, unless a pop happens in the same cycle.
//   pop_i        : remove the head record. The pop is ignored when the FIFO
//                  is empty.
//   pop_data_o   : head record, read straight from the storage registers.
//   full_o       : FIFO is full.
//   empty_o      : FIFO is empty.
// A push and a pop may happen in the same cycle, including when the FIFO is
// full.
module trace_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic [W-1:0] push_data_i,
    input  logic         pop_i,
    output logic [W-1:0] pop_data_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push;
    logic          do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == FULL_CNT);
    assign do_pop  = pop_i && !empty_o;
    // When full, a pop in the same cycle frees the slot that wr_ptr points at.
    assign do_push = push_i && (!full_o || do_pop);

    // Storage is reset as well, so the outputs read as zero after reset.
    assign pop_data_o = mem_q[rd_ptr_q];

    // DEPTH is a power of two, so both pointers wrap without extra logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/monitor_trace_buffer.sv
// monitor_trace_buffer: captures monitor output samples into a queue of
// timestamped trace records.
//   clk, rst                       : clock; asynchronous active-high reset.
//   en                             : capture enable. The timestamp counter
//                                    only runs while en=1.
//   output_0/1, output_0/1_aktv    : monitor streams (signed) and their valids.
//   rec_valid, rec_ready           : record handshake to the consumer.
//   rec_ts, rec_aktv,
//   rec_out_0, rec_out_1           : fields of the presented record.
//   overflow                       : sticky flag, set when a record is dropped.
//   drop_count                     : saturating count of dropped records.
// Handshake: a record transfers on a rising edge where rec_valid and
// rec_ready are both 1. While rec_valid=1 and rec_ready=0, the rec_* outputs
// hold stable. rec_ready has no effect while rec_valid=0.
module monitor_trace_buffer
    import monitor_trace_buffer_pkg::*;
#(
    parameter int DEPTH  = DEF_DEPTH,
    parameter int DATA_W = DEF_DATA_W,
    parameter int TS_W   = DEF_TS_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] output_0,
    input  logic                     output_0_aktv,
    input  logic signed [DATA_W-1:0] output_1,
    input  logic                     output_1_aktv,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [TS_W-1:0]          rec_ts,
    output logic [1:0]               rec_aktv,
    output logic signed [DATA_W-1:0] rec_out_0,
    output logic signed [DATA_W-1:0] rec_out_1,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_count
);

    localparam int REC_W = TS_W + 2 + 2*DATA_W;

    logic [TS_W-1:0]       ts_q, ts_d;
    logic                  overflow_q, overflow_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              capture;
    logic              xfer;
    logic              fifo_full;
    logic              fifo_empty;
    logic [REC_W-1:0]  push_rec;
    logic [REC_W-1:0]  head_rec;
    logic [DATA_W-1:0] cap_out_0;
    logic [DATA_W-1:0] cap_out_1;

    assign capture = en && (output_0_aktv || output_1_aktv);
    assign xfer    = rec_valid && rec_ready;

    // An inactive stream is stored as zero, not as whatever is on its input.
    assign cap_out_0 = output_0_aktv ? output_0 : '0;
    assign cap_out_1 = output_1_aktv ? output_1 : '0;
    assign push_rec  = {ts_q, output_1_aktv, output_0_aktv, cap_out_0, cap_out_1};

    trace_fifo #(
        .DEPTH (DEPTH),
        .W     (REC_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (capture),
        .push_data_i (push_rec),
        .pop_i       (xfer),
        .pop_data_o  (head_rec),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign rec_valid = !fifo_empty;
    assign {rec_ts, rec_aktv, rec_out_0, rec_out_1} = head_rec;
    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;

    always_comb begin
        ts_d       = ts_q;
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (en) begin
            ts_d = ts_q + TS_W'(1);
        end
        // A drop only happens when no transfer frees a slot in the same cycle.
        if (capture && fifo_full && !xfer) begin
            overflow_d = 1'b1;
            drop_cnt_d = sat_inc(drop_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_q       <= '0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            ts_q       <= ts_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

endmodule

// File: tb/tb_monitor_trace_buffer.sv
module tb_monitor_trace_buffer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // main instance: DEPTH=8, DATA_W=64, TS_W=32
    logic               rst;
    logic               en;
    logic signed [63:0] output_0;
    logic               output_0_aktv;
    logic signed [63:0] output_1;
    logic               output_1_aktv;
    logic               rec_valid;
    logic               rec_ready;
    logic [31:0]        rec_ts;
    logic [1:0]         rec_aktv;
    logic signed [63:0] rec_out_0;
    logic signed [63:0] rec_out_1;
    logic               overflow;
    logic [15:0]        drop_count;

    // wrap instance: DEPTH=2, DATA_W=8, TS_W=4
    logic              w_rst;
    logic              w_en;
    logic signed [7:0] w_out0_in;
    logic              w_a0;
    logic signed [7:0] w_out1_in;
    logic              w_a1;
    logic              w_rec_valid;
    logic              w_rec_ready;
    logic [3:0]        w_rec_ts;
    logic [1:0]        w_rec_aktv;
    logic signed [7:0] w_rec_out_0;
    logic signed [7:0] w_rec_out_1;
    logic              w_overflow;
    logic [15:0]       w_drop_count;

    monitor_trace_buffer u_dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .output_0      (output_0),
        .output_0_aktv (output_0_aktv),
        .output_1      (output_1),
        .output_1_aktv (output_1_aktv),
        .rec_valid     (rec_valid),
        .rec_ready     (rec_ready),
        .rec_ts        (rec_ts),
        .rec_aktv      (rec_aktv),
        .rec_out_0     (rec_out_0),
        .rec_out_1     (rec_out_1),
        .overflow      (overflow),
        .drop_count    (drop_count)
    );

    monitor_trace_buffer #(
        .DEPTH  (2),
        .DATA_W (8),
        .TS_W   (4)
    ) u_wrap (
        .clk           (clk),
        .rst           (w_rst),
        .en            (w_en),
        .output_0      (w_out0_in),
        .output_0_aktv (w_a0),
        .output_1      (w_out1_in),
        .output_1_aktv (w_a1),
        .rec_valid     (w_rec_valid),
        .rec_ready     (w_rec_ready),
        .rec_ts        (w_rec_ts),
        .rec_aktv      (w_rec_aktv),
        .rec_out_0     (w_rec_out_0),
        .rec_out_1     (w_rec_out_1),
        .overflow      (w_overflow),
        .drop_count    (w_drop_count)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] model_ts;          // en=1 cycles since reset release
    logic [95:0] exp_q[$];          // {ts, out_0} of queued records, oldest first

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        if (rst) model_ts = '0;
        else if (en) model_ts = model_ts + 32'd1;
        #1;
    endtask

    // Drain every expected record with rec_ready=1, checking capture order.
    task automatic drain(input string tag);
        logic [95:0] e;
        rec_ready = 1'b1;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_valid"}, 64'(rec_valid), 64'd1);
            check({tag, "_ts"}, 64'(rec_ts), 64'(e[95:64]));
            check({tag, "_out0"}, rec_out_0, e[63:0]);
            step();
        end
        check({tag, "_empty"}, 64'(rec_valid), 64'd0);
    endtask

    initial begin
        logic [31:0] ts_frozen;
        rst = 1'b1; en = 1'b0; rec_ready = 1'b0;
        output_0 = '0; output_1 = '0; output_0_aktv = 1'b0; output_1_aktv = 1'b0;
        w_rst = 1'b1; w_en = 1'b0; w_rec_ready = 1'b0;
        w_out0_in = '0; w_out1_in = '0; w_a0 = 1'b0; w_a1 = 1'b0;
        model_ts = '0;
        step(); step();

        // reset state
        check("rst_valid", 64'(rec_valid), 64'd0);
        check("rst_ts", 64'(rec_ts), 64'd0);
        check("rst_aktv", 64'(rec_aktv), 64'd0);
        check("rst_out0", rec_out_0, 64'd0);
        check("rst_out1", rec_out_1, 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_drops", 64'(drop_count), 64'd0);

        // single capture at counter 500; the inactive stream 1 is stored as 0
        rst = 1'b0; en = 1'b1; rec_ready = 1'b1;
        repeat (500) step();
        output_0_aktv = 1'b1; output_0 = 64'sd1; output_1 = 64'sd123;
        check("cap_latency_valid", 64'(rec_valid), 64'd0);
        step();
        output_0_aktv = 1'b0;
        check("c500_valid", 64'(rec_valid), 64'd1);
        check("c500_ts", 64'(rec_ts), 64'd500);
        check("c500_aktv", 64'(rec_aktv), 64'b01);
        check("c500_out0", rec_out_0, 64'd1);
        check("c500_out1", rec_out_1, 64'd0);
        step();
        check("c500_popped", 64'(rec_valid), 64'd0);

        // both streams active, with sign extension of a negative value
        output_0_aktv = 1'b1; output_1_aktv = 1'b1;
        output_0 = -64'sd3; output_1 = 64'sd7;
        step();
        output_0_aktv = 1'b0; output_1_aktv = 1'b0;
        check("both_ts", 64'(rec_ts), 64'd502);
        check("both_aktv", 64'(rec_aktv), 64'b11);
        check("both_out0", rec_out_0, 64'hFFFF_FFFF_FFFF_FFFD);
        check("both_out1", rec_out_1, 64'd7);
        step();
        check("both_popped", 64'(rec_valid), 64'd0);

        // en=0 for 20 cycles with the valids toggling: no records, counter frozen
        ts_frozen = model_ts;
        en = 1'b0;
        for (int i = 0; i < 20; i++) begin
            output_0_aktv = i[0]; output_1_aktv = ~i[0];
            step();
            check("en0_novalid", 64'(rec_valid), 64'd0);
        end
        en = 1'b1; output_0_aktv = 1'b1; output_1_aktv = 1'b0; output_0 = 64'sd9;
        step();
        output_0_aktv = 1'b0;
        check("en0_frozen_ts", 64'(rec_ts), 64'(ts_frozen));
        step();

        // overflow: 10 captures into 8 slots with rec_ready=0
        rec_ready = 1'b0; output_0_aktv = 1'b1;
        for (int i = 0; i < 10; i++) begin
            output_0 = 64'(i);
            if (i < 8) exp_q.push_back({model_ts, 64'(i)});
            step();
        end
        output_0_aktv = 1'b0;
        check("ovf_flag", 64'(overflow), 64'd1);
        check("ovf_drops", 64'(drop_count), 64'd2);
        step(); step();
        check("ovf_hold_ts", 64'(rec_ts), 64'(exp_q[0][95:64]));
        check("ovf_hold_out0", rec_out_0, 64'd0);
        drain("ovf_drain");

        // full FIFO: a capture in the same cycle as a transfer is not dropped
        rec_ready = 1'b0; output_0_aktv = 1'b1;
        for (int i = 0; i < 8; i++) begin
            output_0 = 64'(20 + i);
            exp_q.push_back({model_ts, 64'(20 + i)});
            step();
        end
        check("full_head_out0", rec_out_0, 64'd20);
        void'(exp_q.pop_front());    // the head transfers on the next edge
        rec_ready = 1'b1; output_0 = 64'sd99;
        exp_q.push_back({model_ts, 64'd99});
        step();
        output_0_aktv = 1'b0;
        check("fullx_drops", 64'(drop_count), 64'd2);
        check("fullx_overflow", 64'(overflow), 64'd1);
        drain("fullx_drain");

        // reset with 3 records queued
        rec_ready = 1'b0; output_1_aktv = 1'b1; output_1 = 64'sd5;
        repeat (3) step();
        output_1_aktv = 1'b0;
        check("prerst_valid", 64'(rec_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", 64'(rec_valid), 64'd0);
        check("arst_ts", 64'(rec_ts), 64'd0);
        check("arst_aktv", 64'(rec_aktv), 64'd0);
        check("arst_out1", rec_out_1, 64'd0);
        check("arst_overflow", 64'(overflow), 64'd0);
        check("arst_drops", 64'(drop_count), 64'd0);
        step();
        rst = 1'b0; en = 1'b1; rec_ready = 1'b1; model_ts = '0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("postrst_no_stale", 64'(rec_valid), 64'd0);
        end
        output_0_aktv = 1'b1; output_0 = 64'sh55;
        step();
        output_0_aktv = 1'b0;
        check("postrst_valid", 64'(rec_valid), 64'd1);
        check("postrst_ts", 64'(rec_ts), 64'd3);
        check("postrst_out0", rec_out_0, 64'h55);
        step();

        // TS_W=4: 17 en cycles, then a capture sees ts=17 mod 16 = 1
        w_rst = 1'b0; w_en = 1'b1; w_rec_ready = 1'b1;
        repeat (17) step();
        w_a0 = 1'b1; w_out0_in = 8'sh5A;
        step();
        w_a0 = 1'b0;
        check("wrap_valid", 64'(w_rec_valid), 64'd1);
        check("wrap_ts", 64'(w_rec_ts), 64'd1);
        check("wrap_out0", 64'(w_rec_out_0), 64'h5A);
        check("wrap_drops", 64'(w_drop_count), 64'd0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
